// File: rtl/chorus_tap_scheduler.sv
// chorus_tap_scheduler
// Shares one single-port sample memory (1-cycle registered read) between
// several chorus voices. Each accepted input sample costs one write followed
// by NUM_TAPS pipelined reads, each at its own clamped, modulated delay.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   pkt_s_i            input sample
//   pktChanged_s_i     strobe: pkt_s_i valid
//   tapOffsets_s_i     packed signed per-tap delay offsets (tap k at [14k+13:14k])
//   memWE_c_o          memory write enable
//   memAD_c_o          memory address
//   memDI_c_o          memory write data
//   memDO_i            memory read data (valid the cycle after the address)
//   tapPkt_s_o         delayed sample of the current tap
//   tapIdx_s_o         tap index of tapPkt_s_o
//   tapValid_s_o       strobe: tapPkt_s_o / tapIdx_s_o valid
//   frameDone_c_o      high for one cycle at the end of each frame
//   busy_s_o           high while a frame is in progress
//   overrun_s_o        sticky: a sample arrived while busy
module chorus_tap_scheduler #(
  parameter int unsigned NUM_TAPS   = 3,
  parameter int unsigned BUF_DEPTH  = 4410,
  parameter int unsigned AVG_DELAY  = 882,
  parameter int unsigned PKT_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PKT_WIDTH-1:0]           pkt_s_i,
  input  logic                           pktChanged_s_i,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] tapOffsets_s_i,
  output logic                           memWE_c_o,
  output logic [ADDR_WIDTH-1:0]          memAD_c_o,
  output logic [PKT_WIDTH-1:0]           memDI_c_o,
  input  logic [PKT_WIDTH-1:0]           memDO_i,
  output logic [PKT_WIDTH-1:0]           tapPkt_s_o,
  output logic [2:0]                     tapIdx_s_o,
  output logic                           tapValid_s_o,
  output logic                           frameDone_c_o,
  output logic                           busy_s_o,
  output logic                           overrun_s_o
);

  localparam int unsigned SumWidth = ADDR_WIDTH + 1;
  localparam logic signed [SumWidth-1:0] MaxDelay     = SumWidth'(BUF_DEPTH - 3);
  localparam logic [ADDR_WIDTH-1:0]      MaxDelayAddr = ADDR_WIDTH'(BUF_DEPTH - 3);
  localparam logic [ADDR_WIDTH-1:0]      LastAddr     = ADDR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0]      DepthAddr    = ADDR_WIDTH'(BUF_DEPTH);
  localparam logic [2:0]                 LastTap      = 3'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } stateT;

  stateT state;
  stateT nextState;

  logic [ADDR_WIDTH-1:0]        writeAddr;
  logic [PKT_WIDTH-1:0]         sample;
  logic [ADDR_WIDTH-1:0]        offs [NUM_TAPS];
  logic [2:0]                   tapCnt;
  logic                         rdPend;
  logic [2:0]                   rdIdx;
  logic                         acceptState;
  logic                         accept;
  logic signed [SumWidth-1:0]   curOff;
  logic signed [SumWidth-1:0]   sum;
  logic [ADDR_WIDTH-1:0]        delay;
  logic [ADDR_WIDTH-1:0]        readAddr;

  assign acceptState = (state == IDLE) || (state == DONE);
  assign accept      = acceptState && pktChanged_s_i;

  // Delay for the tap currently being read; offsets come from the copy
  // latched in WRITE so LFO movement mid-frame cannot skew the frame.
  always_comb begin
    curOff = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      if (tapCnt == 3'(k)) curOff = {offs[k][ADDR_WIDTH-1], offs[k]};
    end
    sum = SumWidth'(AVG_DELAY) + curOff;
    if (sum[SumWidth-1]) begin
      delay = '0;
    end else if (sum > MaxDelay) begin
      delay = MaxDelayAddr;
    end else begin
      delay = sum[ADDR_WIDTH-1:0];
    end
    // Wrapped branch stays below BUF_DEPTH, so modulo-2^ADDR_WIDTH
    // intermediate overflow in DepthAddr + writeAddr is harmless.
    readAddr = (writeAddr >= delay) ? (writeAddr - delay)
                                    : (DepthAddr + writeAddr - delay);
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = pktChanged_s_i ? WRITE : IDLE;
      WRITE:   nextState = READ;
      READ:    nextState = (tapCnt == LastTap) ? DRAIN : READ;
      DRAIN:   nextState = DONE;
      DONE:    nextState = pktChanged_s_i ? WRITE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    memWE_c_o     = (state == WRITE);
    memAD_c_o     = (state == READ) ? readAddr : writeAddr;
    memDI_c_o     = sample;
    frameDone_c_o = (state == DONE);
    busy_s_o      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeAddr    <= '0;
      sample       <= '0;
      tapCnt       <= '0;
      rdPend       <= 1'b0;
      rdIdx        <= '0;
      tapPkt_s_o   <= '0;
      tapIdx_s_o   <= '0;
      tapValid_s_o <= 1'b0;
      overrun_s_o  <= 1'b0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) offs[k] <= '0;
    end else begin
      if (accept) sample <= pkt_s_i;
      if (pktChanged_s_i && !acceptState) overrun_s_o <= 1'b1;
      if (state == WRITE) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          offs[k] <= tapOffsets_s_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
        tapCnt <= '0;
      end
      if (state == READ) tapCnt <= tapCnt + 3'd1;
      if (state == DONE) writeAddr <= (writeAddr == LastAddr) ? '0 : writeAddr + ADDR_WIDTH'(1);
      // Read data lands one cycle after its address; register it the cycle after.
      rdPend       <= (state == READ);
      rdIdx        <= tapCnt;
      tapValid_s_o <= rdPend;
      if (rdPend) begin
        tapPkt_s_o <= memDO_i;
        tapIdx_s_o <= rdIdx;
      end
    end
  end

endmodule

// File: tb/tb_chorus_tap_scheduler.sv
// Self-checking bench for chorus_tap_scheduler with a 1-cycle registered-read
// memory model and a frame-level reference model (circular array + clamp).
module tb_chorus_tap_scheduler;

  localparam int N     = 3;
  localparam int DEPTH = 16;
  localparam int AVG   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pkt = '0;
  logic        pktChanged = 1'b0;
  logic [41:0] tapOffsets = '0;
  logic        memWE;
  logic [13:0] memAD;
  logic [15:0] memDI;
  logic [15:0] memDO = '0;
  logic [15:0] tapPkt;
  logic [2:0]  tapIdx;
  logic        tapValid;
  logic        frameDone;
  logic        busy;
  logic        overrun;

  logic [15:0] mem [DEPTH] = '{default: '0};

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] refMem [DEPTH] = '{default: '0};
  int          refWA = 0;
  int          lastWA = 0;
  logic [15:0] expT [N];

  // Per-cycle observations of one frame, index = cycles after T
  logic        obsValid [7];
  logic        obsDone  [7];
  logic        obsBusy  [7];
  logic        obsWE    [7];
  logic        obsOvr   [7];
  logic [2:0]  obsIdx   [7];
  logic [15:0] obsPkt   [7];
  logic [15:0] obsDI    [7];
  logic [13:0] obsAD    [7];

  chorus_tap_scheduler #(
    .NUM_TAPS(N),
    .BUF_DEPTH(DEPTH),
    .AVG_DELAY(AVG),
    .PKT_WIDTH(16),
    .ADDR_WIDTH(14)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pkt_s_i(pkt),
    .pktChanged_s_i(pktChanged),
    .tapOffsets_s_i(tapOffsets),
    .memWE_c_o(memWE),
    .memAD_c_o(memAD),
    .memDI_c_o(memDI),
    .memDO_i(memDO),
    .tapPkt_s_o(tapPkt),
    .tapIdx_s_o(tapIdx),
    .tapValid_s_o(tapValid),
    .frameDone_c_o(frameDone),
    .busy_s_o(busy),
    .overrun_s_o(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWE) mem[memAD[3:0]] <= memDI;
    memDO <= mem[memAD[3:0]];
  end

  function automatic int clampD(input int off);
    int s;
    s = AVG + off;
    if (s < 0) return 0;
    if (s > DEPTH - 3) return DEPTH - 3;
    return s;
  endfunction

  function automatic logic [41:0] pack3(input int a, input int b, input int c);
    logic [41:0] r;
    r[13:0]  = 14'(a);
    r[27:14] = 14'(b);
    r[41:28] = 14'(c);
    return r;
  endfunction

  task automatic model_frame(input logic [15:0] s, input int o0, input int o1, input int o2);
    int offs [N];
    offs = '{o0, o1, o2};
    lastWA = refWA;
    refMem[refWA] = s;
    for (int k = 0; k < N; k++) expT[k] = refMem[(refWA - clampD(offs[k]) + DEPTH) % DEPTH];
    refWA = (refWA + 1) % DEPTH;
  endtask

  task automatic sample_obs(input int j);
    obsValid[j] = tapValid;
    obsDone[j]  = frameDone;
    obsBusy[j]  = busy;
    obsWE[j]    = memWE;
    obsOvr[j]   = overrun;
    obsIdx[j]   = tapIdx;
    obsPkt[j]   = tapPkt;
    obsDI[j]    = memDI;
    obsAD[j]    = memAD;
  endtask

  // Drives one frame starting in the current cycle (T) and records T..T+6.
  // Returns positioned in the DONE cycle.
  task automatic run_frame(input logic [15:0] s, input int o0, input int o1, input int o2,
                           input int pulseAt, input int chgAt,
                           input int n0, input int n1, input int n2);
    pkt        = s;
    pktChanged = 1'b1;
    tapOffsets = pack3(o0, o1, o2);
    #1;
    sample_obs(0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      #1;
      pktChanged = (j == pulseAt);
      if (j == pulseAt) pkt = 16'hBEEF;
      if (j == chgAt) tapOffsets = pack3(n0, n1, n2);
      #1;
      sample_obs(j);
    end
  endtask

  task automatic idle_cycle();
    pktChanged = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (tapPkt !== 16'h0 || tapIdx !== 3'd0 || tapValid !== 1'b0 || frameDone !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0 || memWE !== 1'b0 || memAD !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: got pkt=%h idx=%0d v=%b done=%b busy=%b ovr=%b we=%b ad=%0d, want all 0",
               tapPkt, tapIdx, tapValid, frameDone, busy, overrun, memWE, memAD);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    checks++;
    if (busy !== 1'b0 || tapValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b valid=%b, want 0 0", busy, tapValid);
    end
  endtask

  task automatic test_basic_delay();
    for (int n = 1; n <= 19; n++) begin
      run_frame(16'(n), 0, 0, 0, -1, -1, 0, 0, 0);
      model_frame(16'(n), 0, 0, 0);
      for (int j = 0; j <= 6; j++) begin
        checks++;
        if (obsBusy[j] !== (j >= 1) || obsWE[j] !== (j == 1) || obsDone[j] !== (j == 6)) begin
          errors++;
          $display("FAIL basic_timing n=%0d j=%0d: got busy=%b we=%b done=%b, want %b %b %b",
                   n, j, obsBusy[j], obsWE[j], obsDone[j], j >= 1, j == 1, j == 6);
        end
        if (j < 4) begin
          checks++;
          if (obsValid[j] !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid n=%0d j=%0d: got %b, want 0", n, j, obsValid[j]);
          end
        end
      end
      checks++;
      if (obsDI[1] !== 16'(n) || obsAD[1] !== 14'(lastWA)) begin
        errors++;
        $display("FAIL basic_write n=%0d: got di=%h ad=%0d, want di=%h ad=%0d",
                 n, obsDI[1], obsAD[1], 16'(n), lastWA);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obsValid[4+k] !== 1'b1 || obsIdx[4+k] !== 3'(k) || obsPkt[4+k] !== expT[k]) begin
          errors++;
          $display("FAIL basic_tap n=%0d k=%0d: got v=%b idx=%0d pkt=%h, want v=1 idx=%0d pkt=%h",
                   n, k, obsValid[4+k], obsIdx[4+k], obsPkt[4+k], k, expT[k]);
        end
      end
      idle_cycle();
    end
  endtask

  task automatic test_clamp();
    logic [15:0] want [N];
    want = '{16'h0014, 16'h0010, 16'h0007};
    run_frame(16'h0014, -10, 0, 20, -1, -1, 0, 0, 0);
    model_frame(16'h0014, -10, 0, 20);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsPkt[4+k] !== want[k] || obsPkt[4+k] !== expT[k] || obsValid[4+k] !== 1'b1) begin
        errors++;
        $display("FAIL clamp_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h (model %h)",
                 k, obsValid[4+k], obsPkt[4+k], want[k], expT[k]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic [15:0] s;
      int o [N];
      s = 16'($urandom);
      for (int k = 0; k < N; k++) o[k] = int'($urandom_range(24, 0)) - 12;
      run_frame(s, o[0], o[1], o[2], -1, -1, 0, 0, 0);
      model_frame(s, o[0], o[1], o[2]);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obsValid[4+k] !== 1'b1 || obsIdx[4+k] !== 3'(k) || obsPkt[4+k] !== expT[k]) begin
          errors++;
          $display("FAIL random_tap f=%0d k=%0d off=%0d: got v=%b idx=%0d pkt=%h, want v=1 idx=%0d pkt=%h",
                   f, k, o[k], obsValid[4+k], obsIdx[4+k], obsPkt[4+k], k, expT[k]);
        end
      end
      if ($urandom_range(1, 0) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_wrap();
    for (int guard = 0; guard < DEPTH && refWA != 2; guard++) begin
      logic [15:0] s;
      s = 16'($urandom);
      run_frame(s, 0, 0, 0, -1, -1, 0, 0, 0);
      model_frame(s, 0, 0, 0);
      checks++;
      if (obsAD[1] !== 14'(lastWA) || obsWE[1] !== 1'b1) begin
        errors++;
        $display("FAIL wrap_waddr: got ad=%0d we=%b, want ad=%0d we=1", obsAD[1], obsWE[1], lastWA);
      end
      idle_cycle();
    end
    run_frame(16'hA5A5, 1, 0, -2, -1, -1, 0, 0, 0);
    model_frame(16'hA5A5, 1, 0, -2);
    checks++;
    if (obsAD[1] !== 14'd2 || obsAD[2] !== 14'd13 || obsAD[3] !== 14'd14 || obsAD[4] !== 14'd0) begin
      errors++;
      $display("FAIL wrap_raddr: got w=%0d r0=%0d r1=%0d r2=%0d, want 2 13 14 0",
               obsAD[1], obsAD[2], obsAD[3], obsAD[4]);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsValid[4+k] !== 1'b1 || obsPkt[4+k] !== expT[k]) begin
        errors++;
        $display("FAIL wrap_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h", k, obsValid[4+k], obsPkt[4+k], expT[k]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_overrun_back_to_back();
    logic [15:0] s1;
    logic [15:0] s2;
    s1 = 16'h1234;
    s2 = 16'h5678;
    run_frame(s1, 0, 0, 0, 3, -1, 0, 0, 0);
    model_frame(s1, 0, 0, 0);
    for (int j = 0; j <= 6; j++) begin
      checks++;
      if (obsOvr[j] !== (j >= 4)) begin
        errors++;
        $display("FAIL overrun_flag j=%0d: got %b, want %b", j, obsOvr[j], j >= 4);
      end
    end
    checks++;
    if (obsDone[6] !== 1'b1 || obsDone[5] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_done: got done5=%b done6=%b, want 0 1", obsDone[5], obsDone[6]);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsValid[4+k] !== 1'b1 || obsPkt[4+k] !== expT[k]) begin
        errors++;
        $display("FAIL overrun_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h", k, obsValid[4+k], obsPkt[4+k], expT[k]);
      end
    end
    // Sample presented in DONE: next cycle must be WRITE.
    run_frame(s2, -4, -3, 0, -1, -1, 0, 0, 0);
    model_frame(s2, -4, -3, 0);
    checks++;
    if (obsWE[1] !== 1'b1 || obsDI[1] !== s2 || obsAD[1] !== 14'(lastWA)) begin
      errors++;
      $display("FAIL b2b_write: got we=%b di=%h ad=%0d, want we=1 di=%h ad=%0d",
               obsWE[1], obsDI[1], obsAD[1], s2, lastWA);
    end
    for (int j = 0; j <= 6; j++) begin
      checks++;
      if (obsBusy[j] !== 1'b1 || obsOvr[j] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy_ovr j=%0d: got busy=%b ovr=%b, want 1 1", j, obsBusy[j], obsOvr[j]);
      end
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsValid[4+k] !== 1'b1 || obsPkt[4+k] !== expT[k]) begin
        errors++;
        $display("FAIL b2b_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h", k, obsValid[4+k], obsPkt[4+k], expT[k]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_offset_latch();
    run_frame(16'h0C0C, 0, 0, 0, -1, 3, 3, 3, 3);
    model_frame(16'h0C0C, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsValid[4+k] !== 1'b1 || obsPkt[4+k] !== expT[k]) begin
        errors++;
        $display("FAIL latch_cur_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h", k, obsValid[4+k], obsPkt[4+k], expT[k]);
      end
    end
    idle_cycle();
    run_frame(16'h0D0D, 3, 3, 3, -1, -1, 0, 0, 0);
    model_frame(16'h0D0D, 3, 3, 3);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsValid[4+k] !== 1'b1 || obsPkt[4+k] !== expT[k]) begin
        errors++;
        $display("FAIL latch_next_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h", k, obsValid[4+k], obsPkt[4+k], expT[k]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_reset_midframe();
    pkt        = 16'h7E7E;
    pktChanged = 1'b1;
    tapOffsets = pack3(0, 0, 0);
    refMem[refWA] = 16'h7E7E;
    @(posedge clk); #1;
    pktChanged = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tapPkt !== 16'h0 || tapIdx !== 3'd0 || tapValid !== 1'b0 || frameDone !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0 || memWE !== 1'b0 || memAD !== 14'd0) begin
      errors++;
      $display("FAIL midreset_state: got pkt=%h idx=%0d v=%b done=%b busy=%b ovr=%b we=%b ad=%0d, want all 0",
               tapPkt, tapIdx, tapValid, frameDone, busy, overrun, memWE, memAD);
    end
    refWA = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (tapValid !== 1'b0 || frameDone !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet c=%0d: got v=%b done=%b busy=%b, want 0 0 0", c, tapValid, frameDone, busy);
      end
    end
    run_frame(16'h3C3C, 0, -4, 9, -1, -1, 0, 0, 0);
    model_frame(16'h3C3C, 0, -4, 9);
    checks++;
    if (obsWE[1] !== 1'b1 || obsAD[1] !== 14'd0) begin
      errors++;
      $display("FAIL midreset_first_write: got we=%b ad=%0d, want we=1 ad=0", obsWE[1], obsAD[1]);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obsValid[4+k] !== 1'b1 || obsPkt[4+k] !== expT[k]) begin
        errors++;
        $display("FAIL midreset_tap k=%0d: got v=%b pkt=%h, want v=1 pkt=%h", k, obsValid[4+k], obsPkt[4+k], expT[k]);
      end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic_delay();
    test_clamp();
    test_random();
    test_wrap();
    test_overrun_back_to_back();
    test_offset_latch();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
